// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: requests one instruction at pc, holds it for the decoder,
// then advances pc by sequential, jump, conditional-relative, call or return rules.
//
// state  | meaning
// HALTED | idle, no request; leaves when halt is low
// FETCH  | ir_req high at pc, waiting for ir_ack or timeout
// ISSUE  | ir_out valid, waiting for dec_ready handshake
// ERROR  | fetch timed out; only rst leaves
module fetch_unit #(
    parameter int              AW         = 16,
    parameter int              IW         = 16,
    parameter logic [AW-1:0]   PROG_START = AW'(16'h000F),
    parameter int              OFF_W      = 7,
    parameter int              RAS_DEPTH  = 4,
    parameter int              TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              halt,
    output logic              ir_req,
    output logic [AW-1:0]     ir_addr,
    input  logic              ir_ack,
    input  logic [IW-1:0]     ir_data,
    output logic [IW-1:0]     ir_out,
    output logic              ir_valid,
    input  logic              dec_ready,
    input  logic [2:0]        branch_op,
    input  logic              cond_true,
    input  logic [AW-1:0]     target,
    input  logic [OFF_W-1:0]  offset,
    output logic [AW-1:0]     pc_out,
    output logic              ras_overflow,
    output logic              ras_underflow,
    output logic              fetch_err
);

    localparam int CW   = $clog2(RAS_DEPTH + 1);
    localparam int IDXW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [2:0] OP_JR   = 3'b001;
    localparam logic [2:0] OP_REL  = 3'b010;
    localparam logic [2:0] OP_CALL = 3'b011;
    localparam logic [2:0] OP_RET  = 3'b100;

    typedef enum logic [1:0] {HALTED, FETCH, ISSUE, ERROR} state_t;

    state_t          state;
    logic [AW-1:0]   pc;
    logic [AW-1:0]   pc_inc;
    logic [AW-1:0]   pc_rel;
    logic [AW-1:0]   ras [RAS_DEPTH];
    logic [CW-1:0]   ras_cnt;
    logic [IDXW-1:0] push_idx;
    logic [IDXW-1:0] pop_idx;
    logic [TW-1:0]   wait_cnt;

    assign pc_inc   = pc + AW'(1);
    // Size cast of a signed operand sign-extends; the sum wraps modulo 2^AW.
    assign pc_rel   = pc_inc + AW'($signed(offset));
    assign push_idx = ras_cnt[IDXW-1:0];
    assign pop_idx  = IDXW'(ras_cnt - CW'(1));
    assign ir_addr  = pc;
    assign pc_out   = pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= HALTED;
            pc            <= PROG_START;
            ir_out        <= '0;
            ir_valid      <= 1'b0;
            ir_req        <= 1'b0;
            ras_cnt       <= '0;
            wait_cnt      <= '0;
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
            fetch_err     <= 1'b0;
        end else begin
            case (state)
                HALTED: begin
                    if (!halt) begin
                        state  <= FETCH;
                        ir_req <= 1'b1;
                    end
                end
                FETCH: begin
                    if (ir_ack) begin
                        ir_out   <= ir_data;
                        ir_valid <= 1'b1;
                        ir_req   <= 1'b0;
                        wait_cnt <= '0;
                        state    <= ISSUE;
                    end else begin
                        wait_cnt <= wait_cnt + TW'(1);
                        if (wait_cnt == TW'(TIMEOUT - 1)) begin
                            fetch_err <= 1'b1;
                            ir_req    <= 1'b0;
                            state     <= ERROR;
                        end
                    end
                end
                ISSUE: begin
                    if (dec_ready) begin
                        ir_valid <= 1'b0;
                        ir_req   <= !halt;
                        state    <= halt ? HALTED : FETCH;
                        case (branch_op)
                            OP_JR:  pc <= target;
                            OP_REL: pc <= cond_true ? pc_rel : pc_inc;
                            OP_CALL: begin
                                pc <= target;
                                if (ras_cnt == CW'(RAS_DEPTH)) begin
                                    ras_overflow <= 1'b1;
                                end else begin
                                    ras[push_idx] <= pc_inc;
                                    ras_cnt       <= ras_cnt + CW'(1);
                                end
                            end
                            OP_RET: begin
                                if (ras_cnt == '0) begin
                                    pc            <= pc_inc;
                                    ras_underflow <= 1'b1;
                                end else begin
                                    pc      <= ras[pop_idx];
                                    ras_cnt <= ras_cnt - CW'(1);
                                end
                            end
                            default: pc <= pc_inc;
                        endcase
                    end
                end
                ERROR: begin
                    ir_req   <= 1'b0;
                    ir_valid <= 1'b0;
                end
                default: state <= HALTED;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized op streams checked against
// a transaction-level model of pc and the return stack.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst, halt, ir_ack, dec_ready, cond_true;
    logic [15:0] ir_data, target;
    logic [2:0]  branch_op;
    logic [6:0]  offset;
    logic        ir_req, ir_valid, ras_overflow, ras_underflow, fetch_err;
    logic [15:0] ir_addr, ir_out, pc_out;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] m_pc;
    logic [15:0] m_ras[$];
    logic        m_ovf, m_unf;

    fetch_unit #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .halt(halt), .ir_req(ir_req), .ir_addr(ir_addr),
        .ir_ack(ir_ack), .ir_data(ir_data), .ir_out(ir_out), .ir_valid(ir_valid),
        .dec_ready(dec_ready), .branch_op(branch_op), .cond_true(cond_true),
        .target(target), .offset(offset), .pc_out(pc_out),
        .ras_overflow(ras_overflow), .ras_underflow(ras_underflow), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic void model_reset();
        m_pc = 16'h000F;
        m_ras.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endfunction

    function automatic void model_handshake(input logic [2:0] op, input logic c,
                                            input logic [15:0] t, input logic [6:0] off);
        int o;
        o = off[6] ? int'(off) - 128 : int'(off);
        case (op)
            3'd1: m_pc = t;
            3'd2: m_pc = c ? 16'((int'(m_pc) + 1 + o + 65536) % 65536) : m_pc + 16'd1;
            3'd3: begin
                if (m_ras.size() < 4) m_ras.push_back(m_pc + 16'd1);
                else m_ovf = 1'b1;
                m_pc = t;
            end
            3'd4: begin
                if (m_ras.size() == 0) begin
                    m_unf = 1'b1;
                    m_pc  = m_pc + 16'd1;
                end else begin
                    m_pc = m_ras.pop_back();
                end
            end
            default: m_pc = m_pc + 16'd1;
        endcase
    endfunction

    task automatic do_reset();
        rst = 1'b1; halt = 1'b0; ir_ack = 1'b0; dec_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        model_reset();
    endtask

    // Waits (bounded) for a request, then acks it on the lat-th edge after it was seen.
    task automatic fetch_one(input int lat, input logic [15:0] data,
                             output logic [15:0] addr, output bit to);
        int n;
        n  = 0;
        to = 1'b0;
        while (ir_req !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        if (ir_req !== 1'b1) begin
            to   = 1'b1;
            addr = 16'hxxxx;
            return;
        end
        addr = ir_addr;
        for (int i = 1; i < lat; i++) step();
        ir_ack  = 1'b1;
        ir_data = data;
        step();
        ir_ack  = 1'b0;
        ir_data = 16'h0000;
    endtask

    task automatic issue_one(input logic [2:0] op, input logic c,
                             input logic [15:0] t, input logic [6:0] off);
        branch_op = op; cond_true = c; target = t; offset = off;
        dec_ready = 1'b1;
        step();
        dec_ready = 1'b0;
        branch_op = 3'd0;
        model_handshake(op, c, t, off);
    endtask

    task automatic go_to(input logic [15:0] a);
        logic [15:0] ad;
        bit to;
        fetch_one(1, 16'hA5A5, ad, to);
        issue_one(3'd1, 1'b0, a, 7'd0);
    endtask

    task automatic test_reset();
        rst = 1'b1; halt = 1'b0; ir_ack = 1'b1; dec_ready = 1'b1;
        step();
        step();
        n_cmp++; if (pc_out !== 16'h000F) begin n_err++; $display("FAIL reset_pc: got %h expected %h", pc_out, 16'h000F); end
        n_cmp++; if (ir_req !== 1'b0) begin n_err++; $display("FAIL reset_ir_req: got %b expected 0", ir_req); end
        n_cmp++; if (ir_valid !== 1'b0) begin n_err++; $display("FAIL reset_ir_valid: got %b expected 0", ir_valid); end
        n_cmp++; if (ir_out !== 16'h0000) begin n_err++; $display("FAIL reset_ir_out: got %h expected 0000", ir_out); end
        n_cmp++; if ({ras_overflow, ras_underflow, fetch_err} !== 3'b000) begin
            n_err++; $display("FAIL reset_flags: got %b expected 000", {ras_overflow, ras_underflow, fetch_err}); end
        ir_ack = 1'b0; dec_ready = 1'b0;
    endtask

    task automatic test_seq_start();
        logic [15:0] ad, d;
        bit to;
        do_reset();
        n_cmp++; if (ir_req !== 1'b0) begin n_err++; $display("FAIL start_req_c0: got %b expected 0", ir_req); end
        step();
        n_cmp++; if (ir_req !== 1'b1) begin n_err++; $display("FAIL start_req_c1: got %b expected 1", ir_req); end
        for (int k = 0; k < 3; k++) begin
            d = 16'($urandom);
            fetch_one(2, d, ad, to);
            n_cmp++; if (to || ad !== 16'h000F + 16'(k)) begin
                n_err++; $display("FAIL seq_addr%0d: got %h expected %h", k, ad, 16'h000F + 16'(k)); end
            n_cmp++; if (ir_valid !== 1'b1 || ir_out !== d) begin
                n_err++; $display("FAIL seq_ir_out%0d: got %b/%h expected 1/%h", k, ir_valid, ir_out, d); end
            issue_one(3'd0, 1'b0, 16'h0, 7'd0);
        end
    endtask

    task automatic test_stall();
        logic [15:0] ad, d;
        bit to;
        d = 16'($urandom);
        fetch_one(2, d, ad, to);
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if (ir_valid !== 1'b1 || ir_out !== d || pc_out !== m_pc || ir_req !== 1'b0) begin
                n_err++; $display("FAIL stall%0d: got v=%b out=%h pc=%h req=%b expected v=1 out=%h pc=%h req=0",
                                  i, ir_valid, ir_out, pc_out, ir_req, d, m_pc); end
        end
        issue_one(3'd0, 1'b0, 16'h0, 7'd0);
        n_cmp++; if (pc_out !== m_pc) begin n_err++; $display("FAIL stall_pc_after: got %h expected %h", pc_out, m_pc); end
    endtask

    task automatic test_branches();
        logic [15:0] ad;
        bit to;
        go_to(16'h0020);
        fetch_one(2, 16'h1111, ad, to);
        issue_one(3'd2, 1'b1, 16'h0, 7'h7E);
        fetch_one(2, 16'h2222, ad, to);
        n_cmp++; if (to || ad !== 16'h001F) begin n_err++; $display("FAIL rel_taken: got %h expected 001F", ad); end
        issue_one(3'd1, 1'b0, 16'h0020, 7'd0);
        fetch_one(1, 16'h3333, ad, to);
        issue_one(3'd2, 1'b0, 16'h0, 7'h7E);
        fetch_one(1, 16'h4444, ad, to);
        n_cmp++; if (to || ad !== 16'h0021) begin n_err++; $display("FAIL rel_not_taken: got %h expected 0021", ad); end
        issue_one(3'd1, 1'b0, 16'hFFFF, 7'd0);
        fetch_one(3, 16'h5555, ad, to);
        n_cmp++; if (to || ad !== 16'hFFFF) begin n_err++; $display("FAIL jump_ffff: got %h expected FFFF", ad); end
        issue_one(3'd0, 1'b0, 16'h0, 7'd0);
        fetch_one(1, 16'h6666, ad, to);
        n_cmp++; if (to || ad !== 16'h0000) begin n_err++; $display("FAIL seq_wrap: got %h expected 0000", ad); end
        issue_one(3'd0, 1'b0, 16'h0, 7'd0);
    endtask

    task automatic test_ras();
        logic [15:0] ad;
        bit to;
        do_reset();
        go_to(16'h0100);
        for (int k = 0; k < 5; k++) begin
            fetch_one(2, 16'h7000, ad, to);
            n_cmp++; if (to || ad !== m_pc) begin n_err++; $display("FAIL call_addr%0d: got %h expected %h", k, ad, m_pc); end
            issue_one(3'd3, 1'b0, 16'h0200 + 16'(k) * 16'h0100, 7'd0);
            n_cmp++; if (ras_overflow !== m_ovf) begin
                n_err++; $display("FAIL call_ovf%0d: got %b expected %b", k, ras_overflow, m_ovf); end
        end
        n_cmp++; if (ras_overflow !== 1'b1) begin n_err++; $display("FAIL ovf_final: got %b expected 1", ras_overflow); end
        for (int k = 0; k < 5; k++) begin
            fetch_one(2, 16'h8000, ad, to);
            issue_one(3'd4, 1'b0, 16'h0, 7'd0);
            n_cmp++; if (pc_out !== m_pc || ras_underflow !== m_unf) begin
                n_err++; $display("FAIL ret%0d: got pc=%h unf=%b expected pc=%h unf=%b", k, pc_out, ras_underflow, m_pc, m_unf); end
        end
        n_cmp++; if (ras_underflow !== 1'b1) begin n_err++; $display("FAIL unf_final: got %b expected 1", ras_underflow); end
    endtask

    task automatic test_halt();
        logic [15:0] ad, d;
        bit to;
        halt = 1'b1;
        step();
        n_cmp++; if (ir_req !== 1'b1) begin n_err++; $display("FAIL halt_in_fetch: got req=%b expected 1", ir_req); end
        d = 16'($urandom);
        fetch_one(2, d, ad, to);
        n_cmp++; if (ir_valid !== 1'b1 || ir_out !== d) begin
            n_err++; $display("FAIL halt_issue: got %b/%h expected 1/%h", ir_valid, ir_out, d); end
        issue_one(3'd0, 1'b0, 16'h0, 7'd0);
        step();
        step();
        n_cmp++; if (ir_req !== 1'b0 || ir_valid !== 1'b0 || pc_out !== m_pc) begin
            n_err++; $display("FAIL halted: got req=%b v=%b pc=%h expected 0 0 %h", ir_req, ir_valid, pc_out, m_pc); end
        halt = 1'b0;
        step();
        n_cmp++; if (ir_req !== 1'b1 || ir_addr !== m_pc) begin
            n_err++; $display("FAIL resume: got req=%b addr=%h expected 1 %h", ir_req, ir_addr, m_pc); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] ad;
        bit to;
        go_to(16'h1234);
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_reset();
        n_cmp++; if (pc_out !== 16'h000F || ir_req !== 1'b0) begin
            n_err++; $display("FAIL rst_mid_fetch: got pc=%h req=%b expected 000F 0", pc_out, ir_req); end
        ir_ack = 1'b1; ir_data = 16'hDEAD;
        step();
        ir_ack = 1'b0;
        n_cmp++; if (ir_valid !== 1'b0 || ir_req !== 1'b1) begin
            n_err++; $display("FAIL stale_ack: got v=%b req=%b expected 0 1", ir_valid, ir_req); end
        fetch_one(1, 16'hBEEF, ad, to);
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++; if (ir_valid !== 1'b0 || ir_out !== 16'h0000 || pc_out !== 16'h000F) begin
            n_err++; $display("FAIL rst_mid_issue: got v=%b out=%h pc=%h expected 0 0000 000F", ir_valid, ir_out, pc_out); end
    endtask

    task automatic test_timeout();
        logic [15:0] ad;
        bit to;
        do_reset();
        step();
        fetch_one(4, 16'hCAFE, ad, to);
        n_cmp++; if (to || fetch_err !== 1'b0 || ir_valid !== 1'b1) begin
            n_err++; $display("FAIL ack_at_limit: got err=%b v=%b expected 0 1", fetch_err, ir_valid); end
        do_reset();
        step();
        for (int i = 1; i <= 4; i++) begin
            step();
            if (i < 4) begin
                n_cmp++; if (fetch_err !== 1'b0 || ir_req !== 1'b1) begin
                    n_err++; $display("FAIL wait%0d: got err=%b req=%b expected 0 1", i, fetch_err, ir_req); end
            end else begin
                n_cmp++; if (fetch_err !== 1'b1 || ir_req !== 1'b0 || ir_valid !== 1'b0) begin
                    n_err++; $display("FAIL timeout: got err=%b req=%b v=%b expected 1 0 0", fetch_err, ir_req, ir_valid); end
            end
        end
        ir_ack = 1'b1; dec_ready = 1'b1;
        step();
        step();
        step();
        ir_ack = 1'b0; dec_ready = 1'b0;
        n_cmp++; if (fetch_err !== 1'b1 || ir_req !== 1'b0 || ir_valid !== 1'b0 || pc_out !== 16'h000F) begin
            n_err++; $display("FAIL error_stuck: got err=%b req=%b v=%b pc=%h expected 1 0 0 000F",
                              fetch_err, ir_req, ir_valid, pc_out); end
        do_reset();
        n_cmp++; if (fetch_err !== 1'b0 || pc_out !== 16'h000F) begin
            n_err++; $display("FAIL error_cleared: got err=%b pc=%h expected 0 000F", fetch_err, pc_out); end
    endtask

    task automatic test_random();
        logic [15:0] ad, d, t;
        logic [2:0]  op;
        logic [6:0]  off;
        logic        c;
        bit          to;
        int          lat, stall;
        do_reset();
        for (int k = 0; k < 60; k++) begin
            lat = int'($urandom_range(1, 4));
            stall = int'($urandom_range(0, 2));
            d = 16'($urandom); t = 16'($urandom);
            op = 3'($urandom_range(0, 7));
            off = 7'($urandom); c = 1'($urandom);
            fetch_one(lat, d, ad, to);
            n_cmp++; if (to || ad !== m_pc || ir_out !== d) begin
                n_err++; $display("FAIL rnd_fetch%0d: got addr=%h out=%h expected %h %h", k, ad, ir_out, m_pc, d); end
            for (int i = 0; i < stall; i++) step();
            issue_one(op, c, t, off);
            n_cmp++; if (pc_out !== m_pc || ras_overflow !== m_ovf || ras_underflow !== m_unf || fetch_err !== 1'b0) begin
                n_err++; $display("FAIL rnd_issue%0d op=%0d: got pc=%h ovf=%b unf=%b err=%b expected %h %b %b 0",
                                  k, op, pc_out, ras_overflow, ras_underflow, fetch_err, m_pc, m_ovf, m_unf); end
        end
    endtask

    initial begin
        rst = 1'b1; halt = 1'b0; ir_ack = 1'b0; ir_data = '0; dec_ready = 1'b0;
        cond_true = 1'b0; target = '0; offset = '0; branch_op = '0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_seq_start();
        test_stall();
        test_branches();
        test_ras();
        test_halt();
        test_reset_mid();
        test_timeout();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
